// File: rtl/cdp_ocvt_pkg.sv
// rtl/cdp_ocvt_pkg.sv - shared state encoding and default parameters for the CDP ocvt sequencer
package cdp_ocvt_pkg;

  localparam int LAT_DEF   = 3;
  localparam int LEN_W_DEF = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ocvt_state_e;

endpackage

// File: rtl/cdp_ocvt_vld_pipe.sv
// rtl/cdp_ocvt_vld_pipe.sv - LAT-deep enable-gated valid shift register
// Holds every stage, bubbles included, whenever en_i is low.
module cdp_ocvt_vld_pipe #(
  parameter int LAT = 3
) (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rstn,
  input  logic           en_i,
  input  logic           din_i,
  output logic [LAT-1:0] pipe_o
);

  logic [LAT-1:0] pipe_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      pipe_q <= '0;
    end else if (en_i) begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign pipe_o = pipe_q;

endmodule

// File: rtl/cdp_ocvt_core_seq.sv
// rtl/cdp_ocvt_core_seq.sv - layer sequencer for the CDP ocvt core
// Drives the global core step enable and the rsci wait-control strobes for one layer.
module cdp_ocvt_core_seq
  import cdp_ocvt_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             cfg_op_en,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             chn_in_vd,
  input  logic             chn_out_rdy,
  output logic             core_wen,
  output logic             core_wten,
  output logic             in_iswt0,
  output logic             in_ld_core_psct,
  output logic             out_iswt0,
  output logic             out_ld_core_psct,
  output logic             busy,
  output logic             layer_done
);

  ocvt_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] in_cnt_q;
  logic [LEN_W-1:0] out_cnt_q;
  logic             core_wten_q;
  logic [LAT-1:0]   pipe;
  logic             pipe_last;
  logic             stall;
  logic             accept_in;
  logic             out_fire;
  logic             start;

  cdp_ocvt_vld_pipe #(.LAT(LAT)) u_vld_pipe (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .en_i            (core_wen),
    .din_i           (accept_in),
    .pipe_o          (pipe)
  );

  // One stall freezes both channels; stall never depends on core_wen.
  assign pipe_last = pipe[LAT-1];
  assign in_iswt0  = (state_q == RUN);
  assign out_iswt0 = pipe_last;
  assign stall     = (in_iswt0 & ~chn_in_vd) | (pipe_last & ~chn_out_rdy);
  assign core_wen  = ((state_q == RUN) | (state_q == DRAIN)) & ~stall;
  assign accept_in = in_iswt0 & core_wen;
  assign out_fire  = pipe_last & core_wen;
  assign start     = (state_q == IDLE) & cfg_op_en;

  assign in_ld_core_psct  = in_iswt0;
  assign out_ld_core_psct = out_iswt0;
  assign core_wten        = core_wten_q;
  assign busy             = (state_q != IDLE);
  assign layer_done       = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_op_en) state_d = RUN;
      RUN:     if (accept_in && (in_cnt_q == len_q)) state_d = DRAIN;
      DRAIN:   if (out_fire && (out_cnt_q == len_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= IDLE;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      core_wten_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      core_wten_q <= ~core_wen;
      if (start) begin
        len_q     <= cfg_len;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (accept_in) in_cnt_q  <= in_cnt_q + LEN_W'(1);
        if (out_fire)  out_cnt_q <= out_cnt_q + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdp_ocvt_core_seq.sv
// tb/tb_cdp_ocvt_core_seq.sv - self-checking bench for cdp_ocvt_core_seq
module tb_cdp_ocvt_core_seq;

  localparam int LAT0 = 3;
  localparam int LAT1 = 1;

  logic        clk;
  logic        rstn;
  logic        op_en0, vd0, rdy0;
  logic [12:0] len0;
  logic        wen0, wten0, in0, inld0, out0, outld0, busy0, done0;
  logic        op_en1, vd1, rdy1;
  logic [12:0] len1;
  logic        wen1, wten1, in1, inld1, out1, outld1, busy1, done1;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int fire_cnt = 0;
  int done_cnt = 0;
  int wen_cnt = 0;
  int sb_q[$];

  typedef struct packed {
    logic        op_en;
    logic [12:0] len;
    logic        in_vd;
    logic        out_rdy;
    logic [5:0]  exp;   // {busy, in_iswt0, out_iswt0, core_wen, core_wten, layer_done}
  } vec_t;

  vec_t basic_tbl[$];
  vec_t starve_tbl[$];

  cdp_ocvt_core_seq #(.LAT(LAT0), .LEN_W(13)) u_dut0 (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .cfg_op_en        (op_en0),
    .cfg_len          (len0),
    .chn_in_vd        (vd0),
    .chn_out_rdy      (rdy0),
    .core_wen         (wen0),
    .core_wten        (wten0),
    .in_iswt0         (in0),
    .in_ld_core_psct  (inld0),
    .out_iswt0        (out0),
    .out_ld_core_psct (outld0),
    .busy             (busy0),
    .layer_done       (done0)
  );

  cdp_ocvt_core_seq #(.LAT(LAT1), .LEN_W(13)) u_dut1 (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .cfg_op_en        (op_en1),
    .cfg_len          (len1),
    .chn_in_vd        (vd1),
    .chn_out_rdy      (rdy1),
    .core_wen         (wen1),
    .core_wten        (wten1),
    .in_iswt0         (in1),
    .in_ld_core_psct  (inld1),
    .out_iswt0        (out1),
    .out_ld_core_psct (outld1),
    .busy             (busy1),
    .layer_done       (done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic op, input logic [12:0] l, input logic v,
                              input logic r, input logic [5:0] e);
    vec_t t;
    t.op_en = op; t.len = l; t.in_vd = v; t.out_rdy = r; t.exp = e;
    return t;
  endfunction

  function automatic logic [7:0] obs0();
    return {busy0, in0, inld0, out0, outld0, wen0, wten0, done0};
  endfunction

  function automatic logic [7:0] expand(input logic [5:0] e);
    return {e[5], e[4], e[4], e[3], e[3], e[2], e[1], e[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_tbl(input string tag, input vec_t tbl[$]);
    for (int k = 0; k < tbl.size(); k++) begin
      op_en0 = tbl[k].op_en;
      len0   = tbl[k].len;
      vd0    = tbl[k].in_vd;
      rdy0   = tbl[k].out_rdy;
      @(negedge clk);
      chk($sformatf("%s_c%0d", tag, k), {24'd0, obs0()}, {24'd0, expand(tbl[k].exp)});
      step();
    end
    op_en0 = 1'b0;
  endtask

  task automatic wait_done0(input string tag, input int max_cyc);
    bit seen = 0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(negedge clk);
      if (done0) seen = 1;
      step();
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic clear_counts();
    acc_cnt = 0;
    fire_cnt = 0;
    done_cnt = 0;
  endtask

  // Each beat must leave the pipe exactly LAT enabled steps after it was accepted.
  always @(negedge clk) begin
    if (!rstn) begin
      sb_q.delete();
      wen_cnt = 0;
    end else begin
      if (in0 && wen0) begin
        sb_q.push_back(wen_cnt);
        acc_cnt++;
      end
      if (out0 && wen0) begin
        fire_cnt++;
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          int a;
          a = sb_q.pop_front();
          chk("sb_latency", wen_cnt - a, LAT0);
        end
      end
      if (done0) done_cnt++;
      if (wen0) wen_cnt++;
    end
  end

  initial begin
    // cycle-by-cycle expectations: basic layer, LAT=3, cfg_len=3
    basic_tbl.push_back(mk(1, 13'd3, 1, 1, 6'b000010));
    basic_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b110110));
    basic_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b110100));
    basic_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b110100));
    basic_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b111100));
    basic_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b101100));
    basic_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b101100));
    basic_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b101100));
    basic_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b100001));
    basic_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b000010));
    // input starvation in cycles 2-3
    starve_tbl.push_back(mk(1, 13'd3, 1, 1, 6'b000010));
    starve_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b110110));
    starve_tbl.push_back(mk(0, 13'd3, 0, 1, 6'b110000));
    starve_tbl.push_back(mk(0, 13'd3, 0, 1, 6'b110010));
    starve_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b110110));
    starve_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b110100));
    starve_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b111100));
    starve_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b101100));
    starve_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b101100));
    starve_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b101100));
    starve_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b100001));
    starve_tbl.push_back(mk(0, 13'd3, 1, 1, 6'b000010));

    rstn = 1'b0;
    op_en0 = 0; len0 = '0; vd0 = 1; rdy0 = 1;
    op_en1 = 0; len1 = '0; vd1 = 1; rdy1 = 1;
    @(negedge clk);
    chk("reset_outputs", {24'd0, obs0()}, {24'd0, 8'b0000_0010});
    chk("reset_outputs_lat1", {24'd0, busy1, in1, out1, wen1, wten1, done1, 2'b00},
        {24'd0, 8'b0000_1000});
    step();
    rstn = 1'b1;
    step();

    clear_counts();
    apply_tbl("basic", basic_tbl);
    chk("basic_accepts", acc_cnt, 4);
    chk("basic_fires", fire_cnt, 4);
    chk("basic_done_cnt", done_cnt, 1);

    clear_counts();
    apply_tbl("starve", starve_tbl);
    chk("starve_fires", fire_cnt, 4);

    // output backpressure while pipe_last is high, cycles 4-6
    clear_counts();
    op_en0 = 1; len0 = 13'd3; vd0 = 1; rdy0 = 1;
    step();
    op_en0 = 0;
    for (int c = 1; c <= 7; c++) begin
      rdy0 = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        chk($sformatf("bp_wen_c%0d", c), {31'd0, wen0}, 32'd0);
        chk($sformatf("bp_out_c%0d", c), {31'd0, out0}, 32'd1);
        chk($sformatf("bp_in_c%0d", c), {31'd0, in0}, 32'd1);
      end
      if (c >= 5) chk($sformatf("bp_wten_c%0d", c), {31'd0, wten0}, 32'd1);
      step();
    end
    rdy0 = 1;
    wait_done0("bp", 20);
    step();
    chk("bp_accepts", acc_cnt, 4);
    chk("bp_fires", fire_cnt, 4);
    chk("bp_done_cnt", done_cnt, 1);

    // single beat on the LAT=1 instance
    op_en1 = 1; len1 = 13'd0;
    step();
    op_en1 = 0;
    @(negedge clk);
    chk("single_c1", {26'd0, busy1, in1, out1, wen1, done1, inld1}, {26'd0, 6'b110101});
    step();
    @(negedge clk);
    chk("single_c2", {26'd0, busy1, in1, out1, wen1, done1, outld1}, {26'd0, 6'b101101});
    step();
    @(negedge clk);
    chk("single_c3", {28'd0, busy1, out1, wen1, done1}, {28'd0, 4'b1001});
    step();
    @(negedge clk);
    chk("single_c4", {30'd0, busy1, done1}, 32'd0);
    step();

    // start pulse during RUN ignored, then reset mid-DRAIN
    clear_counts();
    op_en0 = 1; len0 = 13'd3; vd0 = 1; rdy0 = 1;
    step();
    op_en0 = 0;
    step();
    op_en0 = 1; len0 = 13'd7;
    step();
    op_en0 = 0;
    step();
    step();
    @(negedge clk);
    chk("ign_drain_in", {30'd0, busy0, in0}, {30'd0, 2'b10});
    step();
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {24'd0, obs0()}, {24'd0, 8'b0000_0010});
    step();
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_idle", {31'd0, busy0}, 32'd0);
    clear_counts();
    apply_tbl("after_rst", basic_tbl);
    chk("after_rst_fires", fire_cnt, 4);

    // maximum length with random channel handshakes
    clear_counts();
    op_en0 = 1; len0 = 13'h1FFF;
    step();
    op_en0 = 0;
    begin
      bit seen = 0;
      for (int c = 0; c < 60000 && !seen; c++) begin
        vd0  = ($urandom_range(0, 3) != 0);
        rdy0 = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (done0) seen = 1;
        step();
      end
      chk("max_done_seen", {31'd0, seen}, 32'd1);
    end
    vd0 = 1; rdy0 = 1;
    for (int c = 0; c < 5; c++) step();
    chk("max_accepts", acc_cnt, 8192);
    chk("max_fires", fire_cnt, 8192);
    chk("max_done_cnt", done_cnt, 1);
    chk("max_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
